// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  // One radix-2 step per operand bit.
  localparam int unsigned MDU_ITER  = MDU_WIDTH;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_e;

  // Two's-complement magnitude of a value when it is treated as signed.
  function automatic logic [MDU_WIDTH-1:0] mdu_mag(input logic [MDU_WIDTH-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[MDU_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Shift-add multiply / restoring divide datapath with final sign fixup.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds {partial product, multiplier} or {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               div_q;
  logic               neg_q;
  logic               sa_q;
  logic               dz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign a_mag = WIDTH'(mdu_mag(MDU_WIDTH'(a), is_signed));
  assign b_mag = WIDTH'(mdu_mag(MDU_WIDTH'(b), is_signed));

  // One radix-2 step: conditional add for multiply, trial subtract for divide.
  always_comb begin
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
    end else if (step) begin
      if (div_q) begin
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // Operand capture at load and accumulator update each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load) begin
        opb_q   <= is_div ? b_mag : a_mag;
        a_raw_q <= a;
        div_q   <= is_div;
        neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        sa_q    <= is_signed & a[WIDTH-1];
        dz_q    <= is_div & (b == '0);
      end
    end
  end

  // Sign fixup and divide-by-zero override of the raw magnitude result.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = sa_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MDU: FSM, step counter, handshake and architectural HI/LO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  mdu_op_e          op_e;
  logic             is_md, is_div, is_signed;
  logic             load, step, idle_start;

  assign op_e       = mdu_op_e'(op);
  assign is_md      = (op_e == MULT) || (op_e == MULTU) || (op_e == DIV) || (op_e == DIVU);
  assign is_div     = (op_e == DIV) || (op_e == DIVU);
  assign is_signed  = (op_e == MULT) || (op_e == DIV);
  assign idle_start = (state_q == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && is_md) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
    load = idle_start && is_md;
    step = (state_q == RUN);
  end

  // Step counter, done pulse and HI/LO writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= (state_q == FINISH);
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
      if (state_q == FINISH) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (idle_start && (op_e == MTHI)) begin
        hi_q <= rs_val;
      end else if (idle_start && (op_e == MTLO)) begin
        lo_q <= rs_val;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  mdu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (rs_val),
    .b         (rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule
